wb_stream_writer: RTL and testbench
===================================

Name: wb_stream_writer

Overview:
- Wishbone classic-cycle write master that sits directly upstream of the team's Wishbone RAM slave and fills it.
- Accepts a command (start byte address, word count), then consumes that many words from a valid/ready data stream.
- Issues one single-word Wishbone write per word at consecutive word addresses.
- Reports completion, error and the number of words written.

Parameters:
- DATA_WIDTH, 32, data bus width in bits (8, 16, 32 or 64)
- ADDR_WIDTH, 16, byte address width
- SELECT_WIDTH, DATA_WIDTH/8, select lanes (1, 2, 4 or 8)
- LEN_WIDTH, 16, width of the word-count field

Ports:
- clk  input  1  clock; all logic on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- cmd_addr  input  ADDR_WIDTH  start byte address; low $clog2(SELECT_WIDTH) bits ignored, treated as 0
- cmd_len  input  LEN_WIDTH  number of words to write
- cmd_valid  input  1  command valid
- cmd_ready  output  1  high only in IDLE
- s_data  input  DATA_WIDTH  stream data word
- s_valid  input  1  stream word valid
- s_ready  output  1  high only in WAIT_DATA
- adr_o  output  ADDR_WIDTH  ADR_O() byte address
- dat_o  output  DATA_WIDTH  DAT_O() write data
- we_o  output  1  WE_O; constant 1 while stb_o is high
- sel_o  output  SELECT_WIDTH  SEL_O(); all ones while stb_o is high
- stb_o  output  1  STB_O strobe
- cyc_o  output  1  CYC_O; identical to stb_o
- ack_i  input  1  ACK_I acknowledge
- err_i  input  1  ERR_I bus error
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse at command end
- error  output  1  one-cycle pulse coincident with done when terminated by err_i
- words_written  output  LEN_WIDTH  count of acked words for the current/last command

Behaviour:
- Reset (rst_n low, effective immediately, no clock required):
  - state IDLE
  - stb_o, cyc_o, we_o, done, error, busy = 0
  - sel_o, adr_o, dat_o, words_written = 0
  - any in-flight bus cycle is abandoned
- States: IDLE, WAIT_DATA, BUS, FINISH.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid the command is latched: addr reg = cmd_addr with word-offset bits cleared; remaining = cmd_len; words_written cleared to 0.
  - If cmd_len = 0, go to FINISH (no bus activity); otherwise go to WAIT_DATA.
- WAIT_DATA:
  - s_ready = 1.
  - On s_valid, s_data is latched into dat_o; adr_o = addr reg; state goes to BUS.
  - stb_o, cyc_o, we_o = 1 and sel_o = all ones from the next cycle.
  - No timeout: the block waits indefinitely for data.
- BUS:
  - stb_o, cyc_o, adr_o, dat_o are held stable until ack_i or err_i is sampled high.
  - On ack_i (err_i low):
    - stb_o/cyc_o/we_o drop the next cycle; sel_o returns to 0.
    - words_written += 1; remaining -= 1; addr reg += SELECT_WIDTH, wrapping modulo 2^ADDR_WIDTH.
    - Go to WAIT_DATA if remaining > 0, else FINISH.
  - On err_i (priority over a simultaneous ack_i):
    - strobe drops; the word is not counted.
    - Go to FINISH with the error flag set.
- FINISH: done = 1 for exactly one cycle; error = 1 in the same cycle if the error flag is set; flag cleared; return to IDLE.
- Timing against a slave that acks one cycle after strobe (the team's RAM):
  - each word takes 3 cycles: accept, strobe, ack
  - strobe is never high in the cycle after an ack, which avoids double writes with slaves that gate on ~ack
- Edge cases:
  - cmd_valid in a non-IDLE state is ignored and not accepted.
  - s_valid outside WAIT_DATA is not accepted.
  - A word is never lost or duplicated.
  - words_written holds its final value until the next command is accepted.
  - Counter width rule: cmd_len of 2^LEN_WIDTH-1 is legal, and words_written does not overflow.

Test Plan:
- Reset, then cmd_addr=0x0010, cmd_len=4, stream 0xA0..0xA3 back-to-back, RAM model acking 1 cycle after stb -> writes at 0x0010, 0x0014, 0x0018, 0x001C with sel=0xF; done pulse; error=0; words_written=4; exactly 4 acked strobes.
- cmd_len=0 -> done pulse 2 cycles after cmd accept; stb_o never asserted; words_written=0.
- cmd_addr=0xFFFC, cmd_len=2, ADDR_WIDTH=16 -> writes at 0xFFFC then 0x0000 (wrap). Also cmd_addr=0x0013 -> first write at 0x0010.
- Stream stalls 5 cycles between words and slave delays ack by 3 cycles -> adr_o/dat_o stable through wait; no strobe without data; all words written in order.
- err_i asserted (together with ack_i) on the 3rd of 5 words -> done and error pulse together; words_written=2; no further strobes; the next command is accepted normally.
- rst_n low mid-BUS with stb_o high -> stb_o/cyc_o low asynchronously before the next edge; after release, cmd_ready=1 and words_written=0.

Source files
------------

// File: rtl/wb_stream_writer_if.sv
// Wishbone classic-cycle bus bundle between
// the stream writer (master) and a RAM slave.
interface wb_stream_writer_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8
);
  logic [ADDR_WIDTH-1:0]   adr_o;
  logic [DATA_WIDTH-1:0]   dat_o;
  logic                    we_o;
  logic [SELECT_WIDTH-1:0] sel_o;
  logic                    stb_o;
  logic                    cyc_o;
  logic                    ack_i;
  logic                    err_i;

  modport master (
    output adr_o, dat_o, we_o,
    output sel_o, stb_o, cyc_o,
    input  ack_i, err_i
  );

  modport slave (
    input  adr_o, dat_o, we_o,
    input  sel_o, stb_o, cyc_o,
    output ack_i, err_i
  );
endinterface

// File: rtl/wb_stream_writer.sv
// Wishbone write master: takes a (addr, len)
// command and writes len stream words to RAM.
module wb_stream_writer #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8,
  parameter int LEN_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  wb_stream_writer_if.master    wb,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [LEN_WIDTH-1:0]  words_written
);

  localparam int OFF = $clog2(SELECT_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ONE =
    ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK =
    ~((ONE << OFF) - ONE);
  localparam logic [ADDR_WIDTH-1:0] STEP =
    ADDR_WIDTH'(SELECT_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_DATA,
    BUS,
    FINISH
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  remaining;
  logic                  err_flag;

  // Handshake readiness decodes straight off the state register.
  assign cmd_ready = (state == IDLE);
  assign s_ready   = (state == WAIT_DATA);
  assign busy      = (state != IDLE);

  // Command/stream/bus sequencer; strobe drops the cycle after a response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      addr_q        <= '0;
      remaining     <= '0;
      err_flag      <= 1'b0;
      words_written <= '0;
      done          <= 1'b0;
      error         <= 1'b0;
      wb.adr_o      <= '0;
      wb.dat_o      <= '0;
      wb.we_o       <= 1'b0;
      wb.sel_o      <= '0;
      wb.stb_o      <= 1'b0;
      wb.cyc_o      <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            addr_q        <= cmd_addr & ADDR_MASK;
            remaining     <= cmd_len;
            words_written <= '0;
            if (cmd_len == '0) state <= FINISH;
            else               state <= WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (s_valid) begin
            wb.dat_o <= s_data;
            wb.adr_o <= addr_q;
            wb.we_o  <= 1'b1;
            wb.sel_o <= '1;
            wb.stb_o <= 1'b1;
            wb.cyc_o <= 1'b1;
            state    <= BUS;
          end
        end
        BUS: begin
          if (wb.err_i) begin
            wb.we_o  <= 1'b0;
            wb.sel_o <= '0;
            wb.stb_o <= 1'b0;
            wb.cyc_o <= 1'b0;
            err_flag <= 1'b1;
            state    <= FINISH;
          end else if (wb.ack_i) begin
            wb.we_o       <= 1'b0;
            wb.sel_o      <= '0;
            wb.stb_o      <= 1'b0;
            wb.cyc_o      <= 1'b0;
            words_written <= words_written + 1'b1;
            remaining     <= remaining - 1'b1;
            addr_q        <= addr_q + STEP;
            if (remaining == LEN_WIDTH'(1))
              state <= FINISH;
            else
              state <= WAIT_DATA;
          end
        end
        FINISH: begin
          done     <= 1'b1;
          error    <= err_flag;
          err_flag <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_stream_writer.sv
// Randomized directed bench for wb_stream_writer
// with a latency-programmable Wishbone RAM slave.
module tb_wb_stream_writer;

  logic        clk;
  logic        rst_n;
  logic [15:0] cmd_addr;
  logic [15:0] cmd_len;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] words_written;

  wb_stream_writer_if #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(16),
    .SELECT_WIDTH(4)
  ) bus ();

  wb_stream_writer #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(16),
    .SELECT_WIDTH(4),
    .LEN_WIDTH(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cmd_addr(cmd_addr),
    .cmd_len(cmd_len),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .s_data(s_data),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .wb(bus),
    .busy(busy),
    .done(done),
    .error(error),
    .words_written(words_written)
  );

  int checks = 0;
  int errors = 0;
  int cycle = 0;

  int ack_delay = 0;
  int err_at = -1;
  int acks_seen = 0;
  int wcnt = 0;

  int strobes = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  logic [15:0] last_ww;
  logic        last_err;
  logic        p_stb, p_end;
  logic [15:0] p_adr;
  logic [31:0] p_dat;
  logic [15:0] wr_adr[$];
  logic [31:0] wr_dat[$];
  logic [31:0] stim[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // RAM slave: acks ack_delay cycles after first seeing stb, err on err_at
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ack_i <= 1'b0;
      bus.err_i <= 1'b0;
      wcnt      <= 0;
    end else if (bus.stb_o && !bus.ack_i && !bus.err_i) begin
      if (wcnt >= ack_delay) begin
        bus.ack_i <= 1'b1;
        bus.err_i <= (acks_seen == err_at);
        acks_seen <= acks_seen + 1;
        wcnt      <= 0;
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      bus.ack_i <= 1'b0;
      bus.err_i <= 1'b0;
    end
  end

  // Bus protocol monitor and write logger
  always @(negedge clk) begin
    if (!rst_n) begin
      p_stb = 1'b0;
      p_end = 1'b0;
    end else begin
      if (p_stb && p_end)
        chk("stb_after_ack", bus.stb_o, 0);
      if (bus.stb_o) begin
        chk("cyc_eq_stb", bus.cyc_o, 1);
        chk("we_high", bus.we_o, 1);
        chk("sel_ones", bus.sel_o, 4'hF);
        if (p_stb && !p_end) begin
          chk("adr_hold", bus.adr_o, p_adr);
          chk("dat_hold", bus.dat_o, p_dat);
        end else begin
          strobes++;
        end
      end else begin
        chk("cyc_idle", bus.cyc_o, 0);
      end
      if (bus.stb_o && bus.ack_i && !bus.err_i) begin
        wr_adr.push_back(bus.adr_o);
        wr_dat.push_back(bus.dat_o);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cycle;
        last_ww  = words_written;
        last_err = error;
      end else if (error) begin
        chk("error_without_done", error, 0);
      end
      p_stb = bus.stb_o;
      p_end = bus.stb_o && (bus.ack_i || bus.err_i);
      p_adr = bus.adr_o;
      p_dat = bus.dat_o;
    end
  end

  task automatic fill_rand(input int n);
    stim.delete();
    for (int i = 0; i < n; i++) stim.push_back($urandom);
  endtask

  // One command end to end, checked against the arithmetic model
  task automatic run_cmd(input logic [15:0] a, input int len,
                         input int gmin, input int gmax,
                         input int dly, input int ew,
                         input int dd);
    int n_exp, nfeed, n0, s0, d0, acc, t, gap;
    logic [15:0] ea;
    logic hit_err;
    hit_err   = (ew >= 0) && (ew < len);
    n_exp     = hit_err ? ew : len;
    nfeed     = hit_err ? ew + 1 : len;
    ack_delay = dly;
    err_at    = hit_err ? acks_seen + ew : -1;
    n0 = wr_adr.size();
    s0 = strobes;
    d0 = done_cnt;
    t = 0;
    @(negedge clk);
    while (!cmd_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("cmd_ready", cmd_ready, 1);
    cmd_addr  = a;
    cmd_len   = 16'(len);
    cmd_valid = 1'b1;
    acc = cycle;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int i = 0; i < nfeed; i++) begin
      gap = $urandom_range(gmax, gmin);
      repeat (gap) @(posedge clk);
      #1;
      s_data  = stim[i];
      s_valid = 1'b1;
      t = 0;
      @(negedge clk);
      while (!s_ready && t < 200) begin
        @(negedge clk);
        t++;
      end
      chk("s_ready_wait", s_ready, 1);
      @(posedge clk);
      #1 s_valid = 1'b0;
    end
    t = 0;
    while (done_cnt == d0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("done_seen", done_cnt - d0, 1);
    if (dd >= 0) chk("done_cycle", done_cyc - acc, dd);
    repeat (3) @(negedge clk);
    chk("done_once", done_cnt - d0, 1);
    chk("error_pulse", last_err, hit_err);
    chk("ww_at_done", last_ww, n_exp);
    chk("ww_hold", words_written, n_exp);
    chk("write_count", wr_adr.size() - n0, n_exp);
    chk("strobe_count", strobes - s0, nfeed);
    for (int i = 0; i < n_exp && n0 + i < wr_adr.size(); i++) begin
      ea = (a & 16'hFFFC) + 16'(4 * i);
      chk("write_adr", wr_adr[n0 + i], ea);
      chk("write_dat", wr_dat[n0 + i], stim[i]);
    end
  endtask

  initial begin
    int t, len, ew;
    rst_n     = 1'b1;
    cmd_addr  = '0;
    cmd_len   = '0;
    cmd_valid = 1'b0;
    s_data    = '0;
    s_valid   = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_stb", bus.stb_o, 0);
    chk("rst_cyc", bus.cyc_o, 0);
    chk("rst_we", bus.we_o, 0);
    chk("rst_sel", bus.sel_o, 0);
    chk("rst_adr", bus.adr_o, 0);
    chk("rst_dat", bus.dat_o, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ww", words_written, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_s_ready", s_ready, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    stim.delete();
    for (int i = 0; i < 4; i++) stim.push_back(32'hA0 + i);
    run_cmd(16'h0010, 4, 0, 0, 0, -1, 14);

    stim.delete();
    run_cmd(16'h0040, 0, 0, 0, 0, -1, 2);

    fill_rand(2);
    run_cmd(16'hFFFC, 2, 0, 0, 0, -1, 8);

    fill_rand(1);
    run_cmd(16'h0013, 1, 0, 0, 0, -1, 5);

    fill_rand(4);
    run_cmd(16'h2000, 4, 5, 5, 3, -1, -1);

    fill_rand(5);
    run_cmd(16'h0300, 5, 0, 1, 0, 2, -1);

    fill_rand(3);
    run_cmd(16'($urandom), 3, 0, 2, 1, -1, -1);

    for (int r = 0; r < 5; r++) begin
      len = $urandom_range(6, 1);
      ew  = ($urandom_range(2, 0) == 0) ?
            $urandom_range(len - 1, 0) : -1;
      fill_rand(len);
      run_cmd(16'($urandom), len, 0, 3,
              $urandom_range(2, 0), ew, -1);
    end

    ack_delay = 20;
    err_at    = -1;
    @(negedge clk);
    cmd_addr  = 16'h0100;
    cmd_len   = 16'd3;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    s_data  = 32'hDEAD_BEEF;
    s_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!bus.stb_o && t < 50) begin
      @(negedge clk);
      t++;
    end
    s_valid = 1'b0;
    chk("stb_before_rst", bus.stb_o, 1);
    chk("adr_before_rst", bus.adr_o, 16'h0100);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_stb", bus.stb_o, 0);
    chk("async_cyc", bus.cyc_o, 0);
    chk("async_adr", bus.adr_o, 0);
    chk("async_dat", bus.dat_o, 0);
    chk("async_busy", busy, 0);
    #10 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", cmd_ready, 1);
    chk("post_rst_ww", words_written, 0);
    chk("post_rst_stb", bus.stb_o, 0);

    fill_rand(2);
    run_cmd(16'h0500, 2, 0, 0, 0, -1, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
